// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between instruction fetch and load/store.
// Latency: grant registered in IDLE, mem_en 1 cycle later, done MEM_LAT cycles after mem_en.
// Backpressure: requesters hold req until done; the port serves one access at a time.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   if_req/if_addr                  fetch request and address (held until if_done)
//   if_gnt/if_done/if_rdata         fetch ownership, completion pulse, read word
//   d_req/d_we/d_addr/d_wdata       data request, store flag, address, store data
//   d_gnt/d_done/d_rdata            data ownership, completion pulse, load word
//   addr_sel                        address mux select (0 = if_addr, 1 = d_addr)
//   mem_en/mem_we/mem_addr/mem_wdata memory strobe, write enable, address, write data
//   mem_rdata                       memory read data, valid MEM_LAT cycles after mem_en
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        addr_sel,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_INIT   = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_nxt;
  logic          d_own, d_own_nxt;      // 1 = data stage owns the current access
  logic          own_we, own_we_nxt;    // store flag captured at grant time
  logic [CW-1:0] cnt, cnt_nxt;          // BUSY down-counter
  logic [SW-1:0] streak, streak_nxt;    // consecutive data grants while fetch waited

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      d_own  <= 1'b0;
      own_we <= 1'b0;
      cnt    <= '0;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      d_own  <= d_own_nxt;
      own_we <= own_we_nxt;
      cnt    <= cnt_nxt;
      streak <= streak_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    d_own_nxt  = d_own;
    own_we_nxt = own_we;
    cnt_nxt    = cnt;
    streak_nxt = streak;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
          // Data normally wins; fetch is forced once it has waited STARVE_MAX grants.
          if (d_req && !(if_req && streak == STREAK_MAX)) begin
            d_own_nxt  = 1'b1;
            own_we_nxt = d_we;
            // Data can only win with if_req high while streak < STREAK_MAX,
            // so the increment never passes the saturation value.
            if (if_req) streak_nxt = streak + 1'b1;
            else        streak_nxt = '0;
          end else begin
            d_own_nxt  = 1'b0;
            own_we_nxt = 1'b0;
            streak_nxt = '0;
          end
        end
      end
      BUSY: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic active;
  logic resp;
  assign active = (state != IDLE);
  assign resp   = (state == RESP);

  // addr_sel tracks the last owner so the mux is stable through BUSY and RESP.
  assign addr_sel  = d_own;
  assign if_gnt    = active && !d_own;
  assign d_gnt     = active && d_own;
  // The counter holds its load value only in the first BUSY cycle.
  assign mem_en    = (state == BUSY) && (cnt == CNT_INIT);
  assign mem_we    = mem_en && d_own && own_we;
  assign mem_addr  = d_own ? d_addr : if_addr;
  assign mem_wdata = d_gnt ? d_wdata : 32'h0;
  assign if_done   = resp && !d_own;
  assign d_done    = resp && d_own;
  assign if_rdata  = if_done ? mem_rdata : 32'h0;
  assign d_rdata   = (d_done && !own_we) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_done, d_gnt, d_done, addr_sel, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .addr_sel(addr_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Memory model: data appears MEM_LAT cycles after the mem_en cycle.
  logic [31:0] pa [MEM_LAT];
  bit          pv [MEM_LAT];
  always @(posedge clk) begin
    pv[0] <= mem_en;
    pa[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign mem_rdata = pv[MEM_LAT-1] ? rd_pat(pa[MEM_LAT-1]) : 32'hBAD0_BAD0;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
  } acc_t;
  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    int          due;
  } rsp_t;

  acc_t exp_q[$];
  rsp_t resp_q[$];
  bit   spacing_on = 1'b0;
  int   last_en    = -1;

  // Scoreboard: pop expected access at mem_en, expected response at done.
  always @(negedge clk) begin
    acc_t a;
    rsp_t r;
    if (mem_en === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_mem_en", 32'(mem_en), 32'd0);
      else begin
        a = exp_q.pop_front();
        chk("addr_sel", 32'(addr_sel), 32'(a.is_d));
        chk("mem_addr", mem_addr, a.addr);
        chk("mem_we", 32'(mem_we), 32'(a.we));
        chk("mem_wdata", mem_wdata, a.is_d ? a.wdata : 32'h0);
        chk("gnt_owner", 32'({if_gnt, d_gnt}), a.is_d ? 32'd1 : 32'd2);
        if (spacing_on && last_en >= 0) chk("grant_spacing", 32'(cyc - last_en), 32'(MEM_LAT + 2));
        last_en = cyc;
        r.is_d  = a.is_d;
        r.rdata = (a.is_d && a.we) ? 32'h0 : rd_pat(a.addr);
        r.due   = cyc + MEM_LAT;
        resp_q.push_back(r);
      end
    end
    if (if_done === 1'b1 || d_done === 1'b1) begin
      if (resp_q.size() == 0) chk("spurious_done", 32'({if_done, d_done}), 32'd0);
      else begin
        r = resp_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(r.due));
        chk("done_owner", 32'({if_done, d_done}), r.is_d ? 32'd1 : 32'd2);
        chk("owner_rdata", r.is_d ? d_rdata : if_rdata, r.rdata);
        chk("other_rdata", r.is_d ? if_rdata : d_rdata, 32'h0);
      end
    end
  end

  task automatic push_acc(input bit is_d, input logic [31:0] addr, input bit we,
                          input logic [31:0] wdata);
    acc_t a;
    a.is_d = is_d; a.addr = addr; a.we = we; a.wdata = wdata;
    exp_q.push_back(a);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((exp_q.size() != 0 || resp_q.size() != 0) && n < budget);
    chk(tag, 32'(exp_q.size() + resp_q.size()), 32'd0);
  endtask

  task automatic wait_mem_en(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem_en !== 1'b1 && n < 10);
    chk(tag, 32'(mem_en), 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ctl"}, 32'({if_gnt, d_gnt, if_done, d_done, addr_sel, mem_en, mem_we}), 32'd0);
    chk({tag, "_data"}, if_rdata | d_rdata | mem_wdata, 32'h0);
    chk({tag, "_addr"}, mem_addr, if_addr);
  endtask

  task automatic drop_reqs();
    @(posedge clk); #1;
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'h0040_0000; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: single fetch
    push_acc(1'b0, 32'h0040_0000, 1'b0, 32'h0);
    if_req = 1'b1;
    wait_idle(20, "t1_done");
    drop_reqs();
    @(negedge clk);
    chk("t1_idle_gnt", 32'({if_gnt, d_gnt}), 32'd0);

    // 2: single store
    d_addr = 32'h1001_0000; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1;
    push_acc(1'b1, 32'h1001_0000, 1'b1, 32'hDEAD_BEEF);
    d_req = 1'b1;
    wait_idle(20, "t2_done");
    drop_reqs();

    // 3: both held, starvation forcing fetch every fifth grant
    if_addr = 32'h0040_0100; d_addr = 32'h1001_0040; d_we = 1'b0; d_wdata = 32'h1234_5678;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) push_acc(1'b0, 32'h0040_0100, 1'b0, 32'h0);
      else            push_acc(1'b1, 32'h1001_0040, 1'b0, 32'h1234_5678);
    end
    last_en = -1; spacing_on = 1'b1;
    if_req = 1'b1; d_req = 1'b1;
    wait_idle(100, "t3_done");
    drop_reqs();
    spacing_on = 1'b0;

    // 4: data alone keeps streak at 0, then fetch waits 4 data grants
    d_addr = 32'h1001_0080; d_wdata = 32'h0; d_we = 1'b0;
    push_acc(1'b1, 32'h1001_0080, 1'b0, 32'h0);
    push_acc(1'b1, 32'h1001_0080, 1'b0, 32'h0);
    d_req = 1'b1;
    wait_idle(40, "t4a_done");
    if_addr = 32'h0040_0200;
    for (int k = 0; k < 4; k++) push_acc(1'b1, 32'h1001_0080, 1'b0, 32'h0);
    push_acc(1'b0, 32'h0040_0200, 1'b0, 32'h0);
    if_req = 1'b1;
    wait_idle(60, "t4b_done");
    drop_reqs();

    // 5: reset during second BUSY cycle aborts the access
    if_addr = 32'h0040_0300;
    push_acc(1'b0, 32'h0040_0300, 1'b0, 32'h0);
    if_req = 1'b1;
    wait_mem_en("t5_mem_en");
    @(posedge clk); #1;
    reset = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_quiet("t5_abort");
    #1;
    resp_q.delete();
    repeat (6) @(negedge clk);
    if_addr = 32'h0040_0400;
    push_acc(1'b0, 32'h0040_0400, 1'b0, 32'h0);
    if_req = 1'b1;
    wait_idle(20, "t5_fresh_done");
    drop_reqs();

    // 6: fetch request dropped during BUSY still completes
    if_addr = 32'h0040_0500;
    push_acc(1'b0, 32'h0040_0500, 1'b0, 32'h0);
    if_req = 1'b1;
    wait_mem_en("t6_mem_en");
    @(posedge clk); #1;
    if_req = 1'b0;
    wait_idle(20, "t6_done");
    repeat (6) @(negedge clk);
    chk("end_queues", 32'(exp_q.size() + resp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
